// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage of the 16-bit CPU:
//   WORD_SIZE      - instruction / address / PC width
//   BUBBLE_INST    - value held in IF/ID after reset (meaningful only with valid)
//   fetch_state_t  - fetch FSM encodings FS_REQ, FS_HOLD, FS_HALTED
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int          WORD_SIZE   = 16;
    localparam logic [15:0] BUBBLE_INST = 16'h0000;

    typedef enum logic [1:0] {
        FS_REQ    = 2'd0,   // request outstanding to the I-cache
        FS_HOLD   = 2'd1,   // fetched word buffered while decode is stalled
        FS_HALTED = 2'd2    // fetch stopped; only reset leaves this state
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load / hold / flush controls.
// Ports:
//   clk, reset_n        - clock, synchronous active-low reset
//   load                - capture load_inst / load_pc1 and mark valid
//   flush               - invalidate (inst/pc1 are kept; valid qualifies them)
//   load_inst, load_pc1 - incoming instruction and its address + 1
//   valid, inst, pc1    - registered IF/ID contents
// flush has priority over load; with neither asserted all fields hold.
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         flush,
    input  logic [W-1:0] load_inst,
    input  logic [W-1:0] load_pc1,
    output logic         valid,
    output logic [W-1:0] inst,
    output logic [W-1:0] pc1
);
    import fetch_stage_pkg::*;

    logic         valid_reg;
    logic [W-1:0] inst_reg;
    logic [W-1:0] pc1_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_reg <= 1'b0;
            inst_reg  <= W'(BUBBLE_INST);
            pc1_reg   <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            inst_reg  <= load_inst;
            pc1_reg   <= load_pc1;
        end
    end

    assign valid = valid_reg;
    assign inst  = inst_reg;
    assign pc1   = pc1_reg;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, handshakes with the I-cache
// (i_req / i_ready), buffers a word while decode is stalled, and feeds the
// IF/ID register. Handles redirects (highest priority) and halt.
// Ports:
//   clk, reset_n             - clock, synchronous active-low reset
//   i_req, i_addr            - fetch request / address to the I-cache
//   i_data, i_ready          - returned word, completion strobe
//   stall_id                 - decode cannot accept a new instruction
//   redirect, redirect_pc    - taken branch/jump and its target
//   halt                     - stop fetching until reset
//   if_id_valid/inst/pc1     - IF/ID register contents
//   opcode, func_code        - slices of if_id_inst for the control unit
//   fetch_count              - valid IF/ID loads (only with FETCH_PERF_EN)
// Build option: define FETCH_PERF_EN to add the fetch_count port/counter.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                            WORD_SIZE = fetch_stage_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0]          RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_req,
    output logic [WORD_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall_id,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_inst,
    output logic [WORD_SIZE-1:0] if_id_pc1,
    output logic [3:0]           opcode,
    output logic [5:0]           func_code
`ifdef FETCH_PERF_EN
    ,
    output logic [WORD_SIZE-1:0] fetch_count
`endif
);
    import fetch_stage_pkg::*;

    fetch_state_t         state_reg;
    logic [WORD_SIZE-1:0] pc_reg;
    // discard_reg: the cache is still working on an address abandoned by a
    // redirect; its response is dropped and stale_addr_reg keeps i_addr stable
    // until the cache completes it.
    logic                 discard_reg;
    logic [WORD_SIZE-1:0] stale_addr_reg;
    logic [WORD_SIZE-1:0] hold_inst_reg;
    logic [WORD_SIZE-1:0] hold_pc1_reg;

    logic [WORD_SIZE-1:0] pc_plus1;
    logic                 ifid_load;
    logic                 ifid_flush;
    logic [WORD_SIZE-1:0] ifid_inst_next;
    logic [WORD_SIZE-1:0] ifid_pc1_next;

    assign pc_plus1 = pc_reg + 1'b1;   // wraps modulo 2^WORD_SIZE

    assign i_req  = (state_reg == FS_REQ);
    assign i_addr = discard_reg ? stale_addr_reg : pc_reg;

    // IF/ID control. When decode is free and nothing arrives, a bubble is
    // inserted so an instruction is never consumed twice.
    always_comb begin
        ifid_load      = 1'b0;
        ifid_flush     = 1'b0;
        ifid_inst_next = i_data;
        ifid_pc1_next  = pc_plus1;
        if (state_reg != FS_HALTED) begin
            if (redirect || halt) begin
                ifid_flush = 1'b1;
            end else if (state_reg == FS_HOLD) begin
                if (!stall_id) begin
                    ifid_load      = 1'b1;
                    ifid_inst_next = hold_inst_reg;
                    ifid_pc1_next  = hold_pc1_reg;
                end
            end else if (!stall_id) begin
                if (i_ready && !discard_reg) begin
                    ifid_load = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    // Fetch FSM, PC, discard and holding register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= FS_REQ;
            pc_reg         <= RESET_PC;
            discard_reg    <= 1'b0;
            stale_addr_reg <= RESET_PC;
            hold_inst_reg  <= '0;
            hold_pc1_reg   <= '0;
        end else begin
            case (state_reg)
                FS_HALTED: begin
                    state_reg <= FS_HALTED;
                end
                default: begin
                    if (redirect) begin
                        pc_reg    <= redirect_pc;
                        state_reg <= FS_REQ;
                        if (state_reg == FS_REQ && !i_ready) begin
                            discard_reg <= 1'b1;
                            // a second redirect during the same miss keeps
                            // the address the cache is actually serving
                            if (!discard_reg) begin
                                stale_addr_reg <= pc_reg;
                            end
                        end else begin
                            discard_reg <= 1'b0;
                        end
                    end else if (halt) begin
                        state_reg   <= FS_HALTED;
                        discard_reg <= 1'b0;
                    end else if (state_reg == FS_HOLD) begin
                        if (!stall_id) begin
                            state_reg <= FS_REQ;
                        end
                    end else if (i_ready) begin
                        if (discard_reg) begin
                            discard_reg <= 1'b0;
                        end else begin
                            pc_reg <= pc_plus1;
                            if (stall_id) begin
                                hold_inst_reg <= i_data;
                                hold_pc1_reg  <= pc_plus1;
                                state_reg     <= FS_HOLD;
                            end
                        end
                    end
                end
            endcase
        end
    end

    if_id_reg #(
        .W(WORD_SIZE)
    ) u_if_id_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .load_inst (ifid_inst_next),
        .load_pc1  (ifid_pc1_next),
        .valid     (if_id_valid),
        .inst      (if_id_inst),
        .pc1       (if_id_pc1)
    );

    // Raw slices; consumers qualify them with if_id_valid.
    assign opcode    = if_id_inst[WORD_SIZE-1 -: 4];
    assign func_code = if_id_inst[5:0];

`ifdef FETCH_PERF_EN
    logic [WORD_SIZE-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (ifid_load) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign fetch_count = count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all compared against a cycle-level reference model of the
// fetch rules kept in this file.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data = '0;
    logic        i_ready = 1'b0;
    logic        stall_id = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc1;
    logic [3:0]  opcode;
    logic [5:0]  func_code;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    int checks = 0;
    int failures = 0;

    fetch_stage #(
        .WORD_SIZE(16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .stall_id   (stall_id),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .if_id_valid(if_id_valid),
        .if_id_inst (if_id_inst),
        .if_id_pc1  (if_id_pc1),
        .opcode     (opcode),
        .func_code  (func_code)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: what the fetch stage should look like after each edge.
    // ------------------------------------------------------------------
    logic [15:0] m_pc;          // next address to fetch
    bit          m_halted;
    bit          m_holding;     // one fetched word waiting for decode
    logic [15:0] m_hold_inst;
    logic [15:0] m_hold_pc1;
    bit          m_drop;        // response to an abandoned address pending
    logic [15:0] m_stale;       // that abandoned address
    bit          m_valid;
    logic [15:0] m_inst;
    logic [15:0] m_pc1;
    logic [15:0] m_count;

    task automatic model_deliver(input logic [15:0] inst, input logic [15:0] pc1);
        m_valid = 1'b1;
        m_inst  = inst;
        m_pc1   = pc1;
        m_count = m_count + 16'd1;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            m_pc = 16'h0000; m_halted = 0; m_holding = 0; m_drop = 0;
            m_valid = 0; m_inst = 16'h0000; m_pc1 = 16'h0000; m_count = 16'h0000;
            return;
        end
        if (m_halted) return;
        if (redirect) begin
            if (!m_holding && !i_ready) begin
                if (!m_drop) m_stale = m_pc;
                m_drop = 1;
            end else begin
                m_drop = 0;
            end
            m_pc = redirect_pc; m_valid = 0; m_holding = 0;
            return;
        end
        if (halt) begin
            m_halted = 1; m_valid = 0; m_holding = 0; m_drop = 0;
            return;
        end
        if (m_holding) begin
            if (!stall_id) begin
                model_deliver(m_hold_inst, m_hold_pc1);
                m_holding = 0;
            end
            return;
        end
        if (!i_ready || m_drop) begin
            if (i_ready) m_drop = 0;
            if (!stall_id) m_valid = 0;
            return;
        end
        if (stall_id) begin
            m_holding = 1; m_hold_inst = i_data; m_hold_pc1 = m_pc + 16'd1;
        end else begin
            model_deliver(i_data, m_pc + 16'd1);
        end
        m_pc = m_pc + 16'd1;
    endtask

    // One clock: DUT and model advance together; returns on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_ready = 0; stall_id = 0; redirect = 0; halt = 0; reset_n = 1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset_n = 0; i_ready = 1; i_data = 16'hBEEF;
        step();
        step();
        reset_n = 1; i_ready = 0;
        checks++; if (i_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", i_req); end
        checks++; if (i_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", i_addr); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        checks++; if (if_id_inst !== 16'h0000 || if_id_pc1 !== 16'h0000) begin
            failures++; $display("FAIL reset_ifid got inst=%h pc1=%h exp 0000/0000", if_id_inst, if_id_pc1); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_count !== 16'h0000) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
`endif
        $display("reset: i_req=%b i_addr=%h valid=%b", i_req, i_addr, if_id_valid);
    endtask

    task automatic test_hits();
        logic [15:0] words [3];
        words[0] = 16'h4101; words[1] = 16'h4202; words[2] = 16'h4303;
        for (int k = 0; k < 3; k++) begin
            idle_inputs(); i_ready = 1; i_data = words[k];
            checks++; if (i_req !== 1'b1 || i_addr !== 16'(k)) begin
                failures++; $display("FAIL hit_addr%0d got req=%b addr=%h exp req=1 addr=%h", k, i_req, i_addr, 16'(k)); end
            step();
            checks++; if (if_id_valid !== 1'b1 || if_id_inst !== words[k] || if_id_pc1 !== 16'(k + 1)) begin
                failures++; $display("FAIL hit_ifid%0d got v=%b inst=%h pc1=%h exp v=1 inst=%h pc1=%h",
                                     k, if_id_valid, if_id_inst, if_id_pc1, words[k], 16'(k + 1)); end
            $display("hit: addr=%0d inst=%h pc1=%h", k, if_id_inst, if_id_pc1);
        end
    endtask

    task automatic test_miss();
        // two more hits bring the PC to 5
        for (int k = 3; k < 5; k++) begin
            idle_inputs(); i_ready = 1; i_data = 16'h1000 + 16'(k);
            step();
        end
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            checks++; if (i_req !== 1'b1 || i_addr !== 16'h0005) begin
                failures++; $display("FAIL miss_hold%0d got req=%b addr=%h exp req=1 addr=0005", c, i_req, i_addr); end
            if (c > 0) begin
                checks++; if (if_id_valid !== 1'b0) begin
                    failures++; $display("FAIL miss_valid%0d got=%b exp=0", c, if_id_valid); end
            end
            step();
        end
        idle_inputs(); i_ready = 1; i_data = 16'h7123;
        step();
        checks++; if (if_id_valid !== 1'b1 || opcode !== 4'h7 || func_code !== 6'h23 || if_id_pc1 !== 16'h0006) begin
            failures++; $display("FAIL miss_done got v=%b op=%h fn=%h pc1=%h exp v=1 op=7 fn=23 pc1=0006",
                                 if_id_valid, opcode, func_code, if_id_pc1); end
        $display("miss: addr=5 inst=%h opcode=%h", if_id_inst, opcode);
    endtask

    task automatic test_stall();
        idle_inputs(); i_ready = 1; i_data = 16'hF01A; stall_id = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            i_ready = 0;
            checks++; if (i_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_inst !== 16'h7123) begin
                failures++; $display("FAIL stall%0d got req=%b v=%b inst=%h exp req=0 v=1 inst=7123",
                                     c, i_req, if_id_valid, if_id_inst); end
        end
        stall_id = 0;
        step();
        checks++; if (if_id_inst !== 16'hF01A || if_id_pc1 !== 16'h0007 || if_id_valid !== 1'b1) begin
            failures++; $display("FAIL stall_release got inst=%h pc1=%h v=%b exp inst=F01A pc1=0007 v=1",
                                 if_id_inst, if_id_pc1, if_id_valid); end
        checks++; if (i_req !== 1'b1 || i_addr !== 16'h0007) begin
            failures++; $display("FAIL stall_next got req=%b addr=%h exp req=1 addr=0007", i_req, i_addr); end
        $display("stall: released inst=%h next addr=%h", if_id_inst, i_addr);
    endtask

    task automatic test_redirect_miss();
        idle_inputs();
        step();                                   // address 7 misses
        redirect = 1; redirect_pc = 16'h0040;
        step();
        idle_inputs();
        checks++; if (i_addr !== 16'h0007 || if_id_valid !== 1'b0) begin
            failures++; $display("FAIL redir_stale got addr=%h v=%b exp addr=0007 v=0", i_addr, if_id_valid); end
        i_ready = 1; i_data = 16'hDEAD;           // old response: dropped
        step();
        checks++; if (if_id_valid !== 1'b0 || i_addr !== 16'h0040) begin
            failures++; $display("FAIL redir_drop got v=%b addr=%h exp v=0 addr=0040", if_id_valid, i_addr); end
        i_data = 16'h5040;
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_inst !== 16'h5040 || if_id_pc1 !== 16'h0041) begin
            failures++; $display("FAIL redir_arrive got v=%b inst=%h pc1=%h exp v=1 inst=5040 pc1=0041",
                                 if_id_valid, if_id_inst, if_id_pc1); end
        $display("redirect: target inst=%h pc1=%h", if_id_inst, if_id_pc1);
    endtask

    task automatic test_redirect_priority();
        idle_inputs(); redirect = 1; stall_id = 1; i_ready = 1; i_data = 16'h9999; redirect_pc = 16'h0100;
        step();
        idle_inputs();
        checks++; if (i_req !== 1'b1 || i_addr !== 16'h0100 || if_id_valid !== 1'b0) begin
            failures++; $display("FAIL redir_prio got req=%b addr=%h v=%b exp req=1 addr=0100 v=0",
                                 i_req, i_addr, if_id_valid); end
        $display("redirect priority: addr=%h", i_addr);
    endtask

    task automatic test_halt();
        idle_inputs(); halt = 1; i_ready = 1;
        step();
        halt = 0;
        for (int c = 0; c < 10; c++) begin
            i_ready = 1'($urandom_range(0, 1)); i_data = 16'($urandom);
            checks++; if (i_req !== 1'b0 || if_id_valid !== 1'b0) begin
                failures++; $display("FAIL halt%0d got req=%b v=%b exp req=0 v=0", c, i_req, if_id_valid); end
            step();
        end
        idle_inputs(); reset_n = 0;
        step();
        reset_n = 1;
        checks++; if (i_req !== 1'b1 || i_addr !== 16'h0000) begin
            failures++; $display("FAIL halt_reset got req=%b addr=%h exp req=1 addr=0000", i_req, i_addr); end
        $display("halt: resumed at %h", i_addr);
    endtask

    task automatic test_wrap();
        idle_inputs(); redirect = 1; redirect_pc = 16'hFFFF; i_ready = 1;
        step();
        idle_inputs(); i_ready = 1; i_data = 16'h2ABC;
        checks++; if (i_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=FFFF", i_addr); end
        step();
        checks++; if (i_addr !== 16'h0000 || if_id_pc1 !== 16'h0000 || if_id_inst !== 16'h2ABC) begin
            failures++; $display("FAIL wrap got addr=%h pc1=%h inst=%h exp addr=0000 pc1=0000 inst=2ABC",
                                 i_addr, if_id_pc1, if_id_inst); end
        $display("wrap: addr=%h pc1=%h", i_addr, if_id_pc1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 1500; c++) begin
            i_data   = 16'($urandom);
            i_ready  = ($urandom_range(0, 2) != 0);
            stall_id = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 16'hFFFE;
                1:       redirect_pc = 16'hFFFF;
                default: redirect_pc = 16'($urandom);
            endcase
            halt     = ($urandom_range(0, 199) == 0);
            reset_n  = m_halted ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (i_req !== !(m_halted || m_holding) || (i_req === 1'b1 && i_addr !== (m_drop ? m_stale : m_pc))) begin
                failures++; bad++;
                $display("FAIL rand_fetch cyc=%0d got req=%b addr=%h exp req=%b addr=%h",
                         c, i_req, i_addr, !(m_halted || m_holding), m_drop ? m_stale : m_pc);
            end
            checks++;
            if (if_id_valid !== m_valid || if_id_inst !== m_inst || if_id_pc1 !== m_pc1 ||
                opcode !== m_inst[15:12] || func_code !== m_inst[5:0]) begin
                failures++; bad++;
                $display("FAIL rand_ifid cyc=%0d got v=%b inst=%h pc1=%h op=%h fn=%h exp v=%b inst=%h pc1=%h",
                         c, if_id_valid, if_id_inst, if_id_pc1, opcode, func_code, m_valid, m_inst, m_pc1);
            end
`ifdef FETCH_PERF_EN
            checks++;
            if (fetch_count !== m_count) begin
                failures++; bad++;
                $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, fetch_count, m_count);
            end
`endif
        end
        idle_inputs();
        $display("random: 1500 cycles, %0d mismatching cycles", bad);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hits();
        test_miss();
        test_stall();
        test_redirect_miss();
        test_redirect_priority();
        test_halt();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
